// File: rtl/clock_divider_bank_if.sv
// Load port of clock_divider_bank: valid/ready divisor/mode reprogramming
// plus the one-cycle out-of-range error pulse.
interface clock_divider_bank_if #(
  parameter int unsigned WIDTH = 32
);
  logic             load_valid;
  logic             load_ready;
  logic [3:0]       load_ch;
  logic [WIDTH-1:0] load_div;
  logic             load_mode;
  logic             load_err;

  modport master (
    output load_valid, load_ch, load_div, load_mode,
    input  load_ready, load_err
  );

  modport slave (
    input  load_valid, load_ch, load_div, load_mode,
    output load_ready, load_err
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable tick generators. Each channel emits a one-cycle
// tick every div+1 enabled cycles and a toggle or pulse output derived from it.
module clock_divider_bank #(
  parameter int unsigned      CHANNELS    = 4,
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  clock_divider_bank_if.slave load_if,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [WIDTH-1:0]    count_q    [CHANNELS];
  logic [WIDTH-1:0]    count_d    [CHANNELS];
  logic [WIDTH-1:0]    div_q      [CHANNELS];
  logic [WIDTH-1:0]    div_d      [CHANNELS];
  logic [WIDTH-1:0]    pend_div_q [CHANNELS];
  logic [WIDTH-1:0]    pend_div_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] pend_mode_q, pend_mode_d;
  logic                load_err_q, load_err_d;

  logic [15:0]         pend_ext;
  logic [31:0]         ch_ext;
  logic                in_range;
  logic                load_fire;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] apply;

  // Padding pend to all 16 addressable channels makes out-of-range indices read as ready.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pend_q;
  end

  assign ch_ext             = 32'(load_if.load_ch);
  assign in_range           = ch_ext < CHANNELS;
  assign load_if.load_ready = ~pend_ext[load_if.load_ch];
  assign load_fire          = load_if.load_valid && load_if.load_ready;
  assign load_err_d         = load_fire && !in_range;

  always_comb begin
    count_d     = count_q;
    div_d       = div_q;
    pend_div_d  = pend_div_q;
    mode_d      = mode_q;
    out_d       = out_q;
    tick_d      = '0;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    wrap        = '0;
    accept      = '0;
    apply       = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wrap[i]   = enable[i] && (count_q[i] == div_q[i]);
      accept[i] = load_fire && in_range && (ch_ext == i);
      apply[i]  = pend_q[i] && (wrap[i] || !enable[i]);

      if (enable[i]) begin
        if (wrap[i]) begin
          count_d[i] = '0;
          tick_d[i]  = 1'b1;
          out_d[i]   = mode_q[i] ? 1'b1 : ~out_q[i];
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
          if (mode_q[i]) out_d[i] = 1'b0;
        end
      end else if (mode_q[i]) begin
        out_d[i] = 1'b0;
      end

      // Applying after the wrap logic lets the tick of the old period still fire.
      if (apply[i]) begin
        div_d[i]   = pend_div_q[i];
        mode_d[i]  = pend_mode_q[i];
        count_d[i] = '0;
        pend_d[i]  = 1'b0;
        if (pend_mode_q[i] != mode_q[i]) out_d[i] = 1'b0;
      end

      // accept needs pend clear and apply needs it set, so they never coincide.
      if (accept[i]) begin
        pend_div_d[i]  = load_if.load_div;
        pend_mode_d[i] = load_if.load_mode;
        pend_d[i]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count_q[i]    <= '0;
        div_q[i]      <= DEFAULT_DIV;
        pend_div_q[i] <= '0;
      end
      mode_q      <= '0;
      out_q       <= '0;
      tick_q      <= '0;
      pend_q      <= '0;
      pend_mode_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_q       <= div_d;
      pend_div_q  <= pend_div_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      load_err_q  <= load_err_d;
    end
  end

  assign clk_out          = out_q;
  assign tick             = tick_q;
  assign load_if.load_err = load_err_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: a per-channel tick/period model predicts
// every cycle's outputs; a separate monitor pops and compares them.
module tb_clock_divider_bank;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 3;

  typedef struct packed {
    logic           vrdy;
    logic           rdy;
    logic           err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clock_divider_bank_if #(.WIDTH(W)) bus ();

  clock_divider_bank #(
    .CHANNELS    (NCH),
    .WIDTH       (W),
    .DEFAULT_DIV (W'(DEF))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .load_if (bus),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;
  bit   last_accept;

  // Model: togo = enabled edges left before the next tick; toggle level = parity of ticks.
  int unsigned m_div[NCH], m_togo[NCH], m_nticks[NCH], m_pdiv[NCH];
  bit          m_mode[NCH], m_pend[NCH], m_pmode[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]    = DEF;
      m_togo[i]   = DEF;
      m_nticks[i] = 0;
      m_pdiv[i]   = 0;
      m_mode[i]   = 1'b0;
      m_pend[i]   = 1'b0;
      m_pmode[i]  = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic [NCH-1:0] en, input logic v,
                       input logic [3:0] ch, input int unsigned d, input logic m,
                       input logic vrdy = 1'b1);
    exp_t e;
    bit   t, changed, accept;
    int   chi;
    @(negedge clk);
    reset         = rst;
    enable        = en;
    bus.load_valid = v;
    bus.load_ch   = ch;
    bus.load_div  = W'(d);
    bus.load_mode = m;
    #1;
    chi    = int'(ch);
    e      = '0;
    e.vrdy = vrdy;
    if (chi >= NCH) e.rdy = 1'b1;
    else            e.rdy = !m_pend[chi];
    accept      = v && e.rdy;
    last_accept = accept && !rst;
    if (rst) begin
      model_reset();
    end else begin
      e.err = accept && (chi >= NCH);
      for (int i = 0; i < NCH; i++) begin
        t       = en[i] && (m_togo[i] == 0);
        changed = 1'b0;
        if (en[i]) begin
          if (t) begin
            m_nticks[i]++;
            m_togo[i] = m_div[i];
          end else begin
            m_togo[i]--;
          end
        end
        if (m_pend[i] && (t || !en[i])) begin
          m_div[i]  = m_pdiv[i];
          m_togo[i] = m_pdiv[i];
          if (m_pmode[i] != m_mode[i]) begin
            changed     = 1'b1;
            m_mode[i]   = m_pmode[i];
            m_nticks[i] = 0;
          end
          m_pend[i] = 1'b0;
        end
        if (accept && chi == i) begin
          m_pend[i]  = 1'b1;
          m_pdiv[i]  = d;
          m_pmode[i] = m;
        end
        e.tick[i]    = t;
        e.clk_out[i] = changed ? 1'b0 : (m_mode[i] ? t : m_nticks[i][0]);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int k = 0; k < n; k++) cycle(1'b0, en, 1'b0, 4'd0, 0, 1'b0);
  endtask

  task automatic monitor();
    exp_t e;
    logic rdy_s;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk);
      #2;
      rdy_s = bus.load_ready;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.vrdy) check("load_ready", 32'(rdy_s), 32'(e.rdy));
        check("load_err", 32'(bus.load_err), 32'(e.err));
        check("tick", 32'(tick), 32'(e.tick));
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
      end
    end
  endtask

  task automatic driver();
    logic [NCH-1:0] en;
    int             k;
    model_reset();
    cycle(1'b1, '0, 1'b0, 4'd0, 0, 1'b0, 1'b0);
    cycle(1'b1, '0, 1'b0, 4'd0, 0, 1'b0);
    cycle(1'b1, '0, 1'b0, 4'd0, 0, 1'b0);

    // ch0 at default divisor, toggle mode
    idle(20, 4'b0001);

    // ch1 pulse div=2 loaded while disabled, then run
    cycle(1'b0, 4'b0001, 1'b1, 4'd1, 2, 1'b1);
    idle(2, 4'b0001);
    idle(12, 4'b0011);

    // ch0 to div=9, then reload div=1 at count=4 and contend with a second load
    cycle(1'b0, 4'b0011, 1'b1, 4'd0, 9, 1'b0);
    idle(8, 4'b0011);
    k = 0;
    while (m_togo[0] != 5 && k < 40) begin
      idle(1, 4'b0011);
      k++;
    end
    check("reach_count4", 32'(k < 40), 32'd1);
    cycle(1'b0, 4'b0011, 1'b1, 4'd0, 1, 1'b0);
    for (int j = 0; j < 15; j++) begin
      cycle(1'b0, 4'b0011, 1'b1, 4'd0, 1, 1'b0);
      if (last_accept) break;
    end
    idle(10, 4'b0011);

    // load coincident with a ch2 wrap edge
    idle(3, 4'b0111);
    k = 0;
    while (m_togo[2] != 0 && k < 40) begin
      idle(1, 4'b0111);
      k++;
    end
    check("reach_wrap", 32'(k < 40), 32'd1);
    cycle(1'b0, 4'b0111, 1'b1, 4'd2, 1, 1'b0);
    idle(12, 4'b0111);

    // out-of-range channel
    cycle(1'b0, 4'b1111, 1'b1, 4'd7, 5, 1'b1);
    idle(4, 4'b1111);

    // reset with a load pending on ch3 and another presented on ch2
    cycle(1'b0, 4'b1111, 1'b1, 4'd3, 11, 1'b1);
    idle(2, 4'b1111);
    cycle(1'b1, 4'b1111, 1'b1, 4'd2, 6, 1'b1);
    idle(10, 4'b1111);

    en = 4'b1111;
    for (int n = 0; n < 1500; n++) begin
      logic       rst, v, m;
      logic [3:0] ch;
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
      rst = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 99) < 35);
      ch  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      m   = 1'($urandom_range(0, 1));
      cycle(rst, en, v, ch, $urandom_range(0, 9), m);
    end

    @(posedge clk);
    #2;
    done = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    enable         = '0;
    bus.load_valid = 1'b0;
    bus.load_ch    = '0;
    bus.load_div   = '0;
    bus.load_mode  = 1'b0;
    fork
      driver();
      monitor();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
